// File: rtl/alu_driver_pkg.sv
// Shared ALU widths, FSM state encoding and the operand bundle for alu_driver.
// Used by the interface and the top-level driver.
package alu_driver_pkg;

  localparam int DATA_W  = 16;
  localparam int CTL_W   = 3;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Everything the ALU sees for one operation.
  typedef struct packed {
    logic [DATA_W-1:0]  da;
    logic [DATA_W-1:0]  db;
    logic [CTL_W-1:0]   ctl;
    logic [SHIFT_W-1:0] shift;
  } alu_op_t;

endpackage

// File: rtl/alu_driver_if.sv
// Request, ALU and response buses of alu_driver.
// The master modport is the driver side; the slave modport is the issue logic, ALU and consumer side.
interface alu_driver_if
  import alu_driver_pkg::*;
#(
  parameter int TAG_W = 4
);

  logic               REQ_VALID;
  logic               REQ_READY;
  logic [DATA_W-1:0]  REQ_DA;
  logic [DATA_W-1:0]  REQ_DB;
  logic [CTL_W-1:0]   REQ_CTL;
  logic [SHIFT_W-1:0] REQ_SHIFT;
  logic [TAG_W-1:0]   REQ_TAG;

  logic [DATA_W-1:0]  ALU_DA;
  logic [DATA_W-1:0]  ALU_DB;
  logic [CTL_W-1:0]   ALU_CTL;
  logic [SHIFT_W-1:0] ALU_SHIFT;
  logic [DATA_W-1:0]  ALU_DC;
  logic               ALU_OverFlow;

  logic               RSP_VALID;
  logic               RSP_READY;
  logic [DATA_W-1:0]  RSP_DC;
  logic               RSP_OVF;
  logic [TAG_W-1:0]   RSP_TAG;

  modport master (
    input  REQ_VALID, REQ_DA, REQ_DB, REQ_CTL, REQ_SHIFT, REQ_TAG,
    output REQ_READY,
    output ALU_DA, ALU_DB, ALU_CTL, ALU_SHIFT,
    input  ALU_DC, ALU_OverFlow,
    output RSP_VALID, RSP_DC, RSP_OVF, RSP_TAG,
    input  RSP_READY
  );

  modport slave (
    output REQ_VALID, REQ_DA, REQ_DB, REQ_CTL, REQ_SHIFT, REQ_TAG,
    input  REQ_READY,
    input  ALU_DA, ALU_DB, ALU_CTL, ALU_SHIFT,
    output ALU_DC, ALU_OverFlow,
    input  RSP_VALID, RSP_DC, RSP_OVF, RSP_TAG,
    output RSP_READY
  );

endinterface

// File: rtl/alu_driver.sv
// Sequential initiator for the 16-bit combinational ALU: IDLE -> EVAL -> RESP per operation.
// Define ALU_DRV_PIPE_EN to let a new request be accepted in the response handshake cycle.
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  alu_driver_if.master     bus,
  input  logic             OVF_CLR,
  output logic             OVF_STICKY,
  output logic [CNT_W-1:0] OP_COUNT
);

  state_e             state_q, state_d;
  alu_op_t            op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  rsp_dc_q;
  logic               rsp_ovf_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   cnt_q;

  logic req_ready;
  logic rsp_valid;
  logic accept;
  logic capture;
  logic rsp_hs;

  assign accept  = bus.REQ_VALID & req_ready;
  assign capture = (state_q == ST_EVAL);
  assign rsp_hs  = rsp_valid & bus.RSP_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.RSP_READY) begin
`ifdef ALU_DRV_PIPE_EN
          state_d = accept ? ST_EVAL : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_EVAL: req_ready = 1'b0;
      ST_RESP: begin
        rsp_valid = 1'b1;
`ifdef ALU_DRV_PIPE_EN
        // Response registers are separate from the operand registers, so the
        // next operation may load while the current response is handed off.
        req_ready = bus.RSP_READY;
`endif
      end
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Operand registers only change on acceptance; between ops the ALU keeps its last inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q      <= '0;
      tag_q     <= '0;
      rsp_dc_q  <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_tag_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q.da    <= bus.REQ_DA;
        op_q.db    <= bus.REQ_DB;
        op_q.ctl   <= bus.REQ_CTL;
        op_q.shift <= bus.REQ_SHIFT;
        tag_q      <= bus.REQ_TAG;
      end
      if (capture) begin
        rsp_dc_q  <= bus.ALU_DC;
        rsp_ovf_q <= bus.ALU_OverFlow;
        rsp_tag_q <= tag_q;
      end
      if (capture && bus.ALU_OverFlow) begin
        sticky_q <= 1'b1;
      end else if (OVF_CLR) begin
        sticky_q <= 1'b0;
      end
      if (rsp_hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.ALU_DA    = op_q.da;
  assign bus.ALU_DB    = op_q.db;
  assign bus.ALU_CTL   = op_q.ctl;
  assign bus.ALU_SHIFT = op_q.shift;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_DC    = rsp_dc_q;
  assign bus.RSP_OVF   = rsp_ovf_q;
  assign bus.RSP_TAG   = rsp_tag_q;
  assign OVF_STICKY    = sticky_q;
  assign OP_COUNT      = cnt_q;

endmodule
